// File: rtl/demux8_rr_scheduler_pkg.sv
// demux8_rr_scheduler_pkg
//   Shared constants and types for the 8-way round-robin demux scheduler:
//   requester count, select width, default hold limit, hold counter width,
//   FSM state encoding and a one-hot helper.
package demux8_rr_scheduler_pkg;

    localparam int unsigned N                = 8;
    localparam int unsigned SELW             = 3;
    localparam int unsigned MAX_HOLD_DEFAULT = 15;
    localparam int unsigned CNTW             = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux8_rr_scheduler_if.sv
// demux8_rr_scheduler_if
//   Request/grant bundle between the requesters and the scheduler.
//   req, lock          : per-requester request and lock-extension lines
//   gnt, sel, strobe   : one-hot grant, binary owner index, demux enable
//   busy, timeout      : ownership active, forced-revocation pulse
//   master modport = requester side, slave modport = scheduler side.
interface demux8_rr_scheduler_if;
    import demux8_rr_scheduler_pkg::*;

    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic            strobe;
    logic            busy;
    logic            timeout;

    modport master (
        output req, lock,
        input  gnt, sel, strobe, busy, timeout
    );

    modport slave (
        input  req, lock,
        output gnt, sel, strobe, busy, timeout
    );

endinterface

// File: rtl/demux8_rr_scheduler_rr_pick8.sv
// rr_pick8
//   Combinational rotating priority encoder. Scans req starting at ptr and
//   wrapping modulo 8; returns the first set index.
//   req   : request vector
//   ptr   : highest-priority index
//   found : at least one request set
//   idx   : selected index (0 when found is low)
module rr_pick8
    import demux8_rr_scheduler_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // SELW-bit addition wraps naturally modulo 8
            cand = ptr + SELW'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/demux8_rr_scheduler.sv
// demux8_rr_scheduler
//   Round-robin scheduler for one shared 1-to-8 demux strobe path.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : slave side of demux8_rr_scheduler_if
//              (req/lock in; gnt/sel/strobe/busy/timeout out, all registered)
//   MAX_HOLD : max consecutive cycles one owner keeps the grant (1..255)
module demux8_rr_scheduler
    import demux8_rr_scheduler_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    demux8_rr_scheduler_if.slave  bus
);

    state_t          state;
    logic [N-1:0]    gnt_q;
    logic [SELW-1:0] sel_q;
    logic            strobe_q;
    logic            busy_q;
    logic            timeout_q;
    logic [SELW-1:0] ptr;
    logic [CNTW-1:0] cnt;

    logic [SELW-1:0] pick_ptr;
    logic            pick_found;
    logic [SELW-1:0] pick_idx;
    logic            owner_wants;
    logic            hold;

    // ptr only advances on release, so while an owner is active the next
    // scan must start just past the owner rather than at the stale ptr.
    assign pick_ptr    = (state == GRANT) ? sel_q + SELW'(1) : ptr;
    assign owner_wants = bus.req[sel_q] && bus.lock[sel_q];
    assign hold        = (state == GRANT) && owner_wants &&
                         (cnt < CNTW'(MAX_HOLD - 1));

    rr_pick8 u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= GRANT;
                        gnt_q    <= onehot(pick_idx);
                        sel_q    <= pick_idx;
                        strobe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                GRANT: begin
                    if (hold) begin
                        cnt <= cnt + CNTW'(1);
                    end else begin
                        ptr <= sel_q + SELW'(1);
                        // Not holding while the owner still asks to keep it
                        // means the hold limit ended the grant.
                        timeout_q <= owner_wants;
                        if (pick_found) begin
                            gnt_q <= onehot(pick_idx);
                            sel_q <= pick_idx;
                            cnt   <= '0;
                        end else begin
                            state    <= IDLE;
                            gnt_q    <= '0;
                            strobe_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.strobe  = strobe_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_demux8_rr_scheduler.sv
// tb_demux8_rr_scheduler
//   Directed vectors push expected outputs into a scoreboard queue; a monitor
//   sampling 1 time unit after each rising edge pops and compares. A random
//   phase follows with invariant and starvation-bound checks.
module tb_demux8_rr_scheduler;
    import demux8_rr_scheduler_pkg::*;

    localparam int unsigned MH = 15;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       strobe;
        logic       busy;
        logic       timeout;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    demux8_rr_scheduler_if bus ();

    demux8_rr_scheduler #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic ok, input string detail);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: %s", nm, detail);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] lk,
                        input logic [7:0] g, input logic [2:0] s, input logic to,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.lock = lk;
        e.gnt = g;
        e.sel = s;
        e.strobe = (g != 8'h00);
        e.busy = (g != 8'h00);
        e.timeout = to;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: scoreboard compare plus invariants and starvation tracking
    int unsigned wait_cnt[8];

    initial begin
        exp_t e;
        logic [7:0] g;
        logic [2:0] s;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            g = bus.gnt;
            s = bus.sel;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name,
                      g === e.gnt && s === e.sel && bus.strobe === e.strobe &&
                      bus.busy === e.busy && bus.timeout === e.timeout,
                      $sformatf("got gnt=%h sel=%0d strobe=%b busy=%b timeout=%b, want gnt=%h sel=%0d strobe=%b busy=%b timeout=%b",
                                g, s, bus.strobe, bus.busy, bus.timeout,
                                e.gnt, e.sel, e.strobe, e.busy, e.timeout));
            end
            check("inv_onehot", $onehot0(g), $sformatf("gnt=%h not one-hot/zero", g));
            check("inv_strobe", bus.strobe === (|g), $sformatf("strobe=%b gnt=%h", bus.strobe, g));
            check("inv_busy", bus.busy === bus.strobe, $sformatf("busy=%b strobe=%b", bus.busy, bus.strobe));
            if (bus.strobe)
                check("inv_gnt_sel", g[s] === 1'b1, $sformatf("gnt=%h sel=%0d", g, s));
            for (int i = 0; i < 8; i++) begin
                if (rst || !bus.req[i] || g[i]) wait_cnt[i] = 0;
                else wait_cnt[i]++;
                if (wait_cnt[i] > 8 * MH) begin
                    check("starvation", 1'b0,
                          $sformatf("requester %0d waited %0d cycles, limit %0d", i, wait_cnt[i], 8 * MH));
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        logic [7:0] rr;
        bus.req  = '0;
        bus.lock = '0;

        // Reset: X then all-ones on req/lock must not leak through
        step(1'b1, 8'hxx, 8'hxx, 8'h00, 3'd0, 1'b0, "reset_x");
        step(1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, "reset_ff");

        // Rotation 0..7,0 with no bubbles
        for (int i = 0; i < 9; i++)
            step(1'b0, 8'hFF, 8'h00, onehot(3'(i % 8)), 3'(i % 8), 1'b0, "rotate");

        // Lock to the hold limit: owner 2 for 15 cycles, then timeout to 5
        for (int i = 0; i < 15; i++)
            step(1'b0, 8'h24, 8'h04, 8'h04, 3'd2, 1'b0, "lock_hold");
        step(1'b0, 8'h24, 8'h04, 8'h20, 3'd5, 1'b1, "lock_timeout");

        // Owner 2 again, lock dropped at its 4th cycle: no timeout
        step(1'b0, 8'h24, 8'h00, 8'h04, 3'd2, 1'b0, "relock_start");
        for (int i = 0; i < 3; i++)
            step(1'b0, 8'h24, 8'h04, 8'h04, 3'd2, 1'b0, "relock_hold");
        step(1'b0, 8'h24, 8'h00, 8'h20, 3'd5, 1'b0, "unlock_release");

        // Sparse wrap from ptr 6, then idle keeps sel
        step(1'b0, 8'h09, 8'h00, 8'h01, 3'd0, 1'b0, "sparse_wrap");
        step(1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, "to_idle");
        step(1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, "idle_stay");

        // Owner 3 locked up to cnt 7, then reset mid-grant
        for (int i = 0; i < 8; i++)
            step(1'b0, 8'h08, 8'h08, 8'h08, 3'd3, 1'b0, "lock3");
        step(1'b1, 8'h08, 8'h08, 8'h00, 3'd0, 1'b0, "reset_midgrant");
        step(1'b0, 8'h08, 8'h00, 8'h08, 3'd3, 1'b0, "after_reset");

        // Non-owner lock ignored
        step(1'b0, 8'h0A, 8'h02, 8'h02, 3'd1, 1'b0, "handover_1");
        step(1'b0, 8'h0A, 8'h08, 8'h08, 3'd3, 1'b0, "nonowner_lock");
        step(1'b0, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, "idle_keep_sel");

        // Random sweep with sticky requests
        rr = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7, 0) == 0) rr[b] = ~rr[b];
            bus.req  = rr;
            bus.lock = 8'($urandom);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drain", exp_q.size() == 0,
              $sformatf("%0d expectations left, want 0", exp_q.size()));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
